// File: rtl/grant_dispatcher.sv
// Collects request pulses into sticky pending bits, feeds them to an external
// priority arbiter, and issues the registered winner as one valid/ready transaction.
module grant_dispatcher #(
    parameter int WORD_WIDTH  = 8,
    parameter int INDEX_WIDTH = 3
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [WORD_WIDTH-1:0]  req_pulse,
    output logic [WORD_WIDTH-1:0]  requests,
    input  logic [WORD_WIDTH-1:0]  grant,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INDEX_WIDTH-1:0] out_index,
    output logic [WORD_WIDTH-1:0]  out_grant,
    output logic [WORD_WIDTH-1:0]  done,
    output logic                   busy
);

    // state | meaning
    // IDLE  | no transaction outstanding; registers the next arbiter grant
    // ISSUE | out_valid high; winner held stable until out_ready
    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t                 state, state_next;
    logic [WORD_WIDTH-1:0]  pending, pending_next;
    logic [WORD_WIDTH-1:0]  grant_reg_next;
    logic [INDEX_WIDTH-1:0] index_next;
    logic [WORD_WIDTH-1:0]  done_next;
    logic [WORD_WIDTH-1:0]  inflight_mask;
    logic [WORD_WIDTH-1:0]  clear_vec;
    logic [WORD_WIDTH-1:0]  grant_low;
    logic [INDEX_WIDTH-1:0] grant_index;
    logic                   handshake;

    assign out_valid     = (state == ISSUE);
    assign busy          = (state == ISSUE);
    assign inflight_mask = (state == ISSUE) ? out_grant : '0;
    assign requests      = pending & ~inflight_mask;
    assign handshake     = out_valid && out_ready;
    assign clear_vec     = handshake ? out_grant : '0;

    // Isolating the lowest set bit keeps a multi-hot grant from issuing two winners.
    assign grant_low = grant & (~grant + WORD_WIDTH'(1));

    always_comb begin
        grant_index = '0;
        for (int i = WORD_WIDTH - 1; i >= 0; i--) begin
            if (grant[i]) begin
                grant_index = INDEX_WIDTH'(i);
            end
        end
    end

    always_comb begin
        state_next     = state;
        grant_reg_next = out_grant;
        index_next     = out_index;
        done_next      = '0;
        // set has priority over the handshake clear on the same bit
        pending_next   = (pending & ~clear_vec) | req_pulse;
        case (state)
            IDLE: begin
                if (grant != '0) begin
                    grant_reg_next = grant_low;
                    index_next     = grant_index;
                    state_next     = ISSUE;
                end
            end
            ISSUE: begin
                if (handshake) begin
                    done_next  = out_grant;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            pending   <= '0;
            out_grant <= '0;
            out_index <= '0;
            done      <= '0;
        end else begin
            state     <= state_next;
            pending   <= pending_next;
            out_grant <= grant_reg_next;
            out_index <= index_next;
            done      <= done_next;
        end
    end

endmodule

// File: tb/tb_grant_dispatcher.sv
// Directed bench for grant_dispatcher with a lowest-index-wins arbiter closing the loop.
module tb_grant_dispatcher;

    localparam int W  = 8;
    localparam int IW = 3;

    logic          clock;
    logic          reset_n;
    logic [W-1:0]  req_pulse;
    logic [W-1:0]  requests;
    logic [W-1:0]  grant;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_index;
    logic [W-1:0]  out_grant;
    logic [W-1:0]  done;
    logic          busy;

    logic          ovr;
    logic [W-1:0]  ovr_grant;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0]  req;
        logic          rdy;
        logic          valid;
        logic [IW-1:0] idx;
        logic [W-1:0]  og;
        logic [W-1:0]  dn;
        logic [W-1:0]  reqs;
        logic          bsy;
    } vec_t;

    vec_t vecs[25];

    grant_dispatcher #(.WORD_WIDTH(W), .INDEX_WIDTH(IW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_pulse (req_pulse),
        .requests  (requests),
        .grant     (grant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_grant (out_grant),
        .done      (done),
        .busy      (busy)
    );

    // arbiter: bit 0 highest priority; override lets the bench inject a bad multi-hot grant
    assign grant = ovr ? ovr_grant : (requests & (~requests + 8'd1));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [W-1:0] req, input logic rdy, input logic valid,
                                input logic [IW-1:0] idx, input logic [W-1:0] og,
                                input logic [W-1:0] dn, input logic [W-1:0] reqs,
                                input logic bsy);
        vec_t v;
        v.req = req; v.rdy = rdy; v.valid = valid; v.idx = idx;
        v.og = og; v.dn = dn; v.reqs = reqs; v.bsy = bsy;
        return v;
    endfunction

    task automatic step(input logic [W-1:0] req, input logic rdy);
        @(negedge clock);
        req_pulse = req;
        out_ready = rdy;
        @(posedge clock);
        #1;
    endtask

    initial begin
        // single request at index 5
        vecs[0]  = mk(8'h20, 1, 0, 0, 8'h00, 8'h00, 8'h20, 0);
        vecs[1]  = mk(8'h00, 1, 1, 5, 8'h20, 8'h00, 8'h00, 1);
        vecs[2]  = mk(8'h00, 1, 0, 5, 8'h20, 8'h20, 8'h00, 0);
        vecs[3]  = mk(8'h00, 0, 0, 5, 8'h20, 8'h00, 8'h00, 0);
        // three requests served in priority order 1, 4, 7
        vecs[4]  = mk(8'h92, 1, 0, 5, 8'h20, 8'h00, 8'h92, 0);
        vecs[5]  = mk(8'h00, 1, 1, 1, 8'h02, 8'h00, 8'h90, 1);
        vecs[6]  = mk(8'h00, 1, 0, 1, 8'h02, 8'h02, 8'h90, 0);
        vecs[7]  = mk(8'h00, 1, 1, 4, 8'h10, 8'h00, 8'h80, 1);
        vecs[8]  = mk(8'h00, 1, 0, 4, 8'h10, 8'h10, 8'h80, 0);
        vecs[9]  = mk(8'h00, 1, 1, 7, 8'h80, 8'h00, 8'h00, 1);
        vecs[10] = mk(8'h00, 1, 0, 7, 8'h80, 8'h80, 8'h00, 0);
        vecs[11] = mk(8'h00, 0, 0, 7, 8'h80, 8'h00, 8'h00, 0);
        // stall on index 4, higher-priority request arrives and must not preempt
        vecs[12] = mk(8'h10, 0, 0, 7, 8'h80, 8'h00, 8'h10, 0);
        vecs[13] = mk(8'h00, 0, 1, 4, 8'h10, 8'h00, 8'h00, 1);
        vecs[14] = mk(8'h01, 0, 1, 4, 8'h10, 8'h00, 8'h01, 1);
        vecs[15] = mk(8'h00, 0, 1, 4, 8'h10, 8'h00, 8'h01, 1);
        vecs[16] = mk(8'h00, 1, 0, 4, 8'h10, 8'h10, 8'h01, 0);
        vecs[17] = mk(8'h00, 0, 1, 0, 8'h01, 8'h00, 8'h00, 1);
        vecs[18] = mk(8'h00, 1, 0, 0, 8'h01, 8'h01, 8'h00, 0);
        // set wins over clear on the completing bit
        vecs[19] = mk(8'h08, 0, 0, 0, 8'h01, 8'h00, 8'h08, 0);
        vecs[20] = mk(8'h00, 0, 1, 3, 8'h08, 8'h00, 8'h00, 1);
        vecs[21] = mk(8'h08, 1, 0, 3, 8'h08, 8'h08, 8'h08, 0);
        vecs[22] = mk(8'h00, 1, 1, 3, 8'h08, 8'h00, 8'h00, 1);
        vecs[23] = mk(8'h00, 1, 0, 3, 8'h08, 8'h08, 8'h00, 0);
        vecs[24] = mk(8'h00, 0, 0, 3, 8'h08, 8'h00, 8'h00, 0);

        reset_n   = 1'b0;
        req_pulse = '0;
        out_ready = 1'b0;
        ovr       = 1'b0;
        ovr_grant = '0;
        #1;
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_index", 32'(out_index), 32'd0);
        chk("reset_grant", 32'(out_grant), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        for (int c = 0; c < 10; c++) begin
            step(8'h00, 1'b0);
            chk("idle_requests", 32'(requests), 32'd0);
            chk("idle_valid",    32'(out_valid), 32'd0);
            chk("idle_done",     32'(done), 32'd0);
            chk("idle_busy",     32'(busy), 32'd0);
        end

        for (int k = 0; k < 25; k++) begin
            step(vecs[k].req, vecs[k].rdy);
            chk($sformatf("v%0d_valid", k),    32'(out_valid), 32'(vecs[k].valid));
            chk($sformatf("v%0d_index", k),    32'(out_index), 32'(vecs[k].idx));
            chk($sformatf("v%0d_grant", k),    32'(out_grant), 32'(vecs[k].og));
            chk($sformatf("v%0d_done", k),     32'(done),      32'(vecs[k].dn));
            chk($sformatf("v%0d_requests", k), 32'(requests),  32'(vecs[k].reqs));
            chk($sformatf("v%0d_busy", k),     32'(busy),      32'(vecs[k].bsy));
        end

        // multi-hot grant from a misbehaving arbiter: only the lowest bit is taken
        @(negedge clock);
        ovr = 1'b1; ovr_grant = 8'h14; req_pulse = '0; out_ready = 1'b0;
        @(posedge clock); #1;
        chk("multi_valid", 32'(out_valid), 32'd1);
        chk("multi_index", 32'(out_index), 32'd2);
        chk("multi_grant", 32'(out_grant), 32'h04);
        @(negedge clock);
        ovr = 1'b0;
        step(8'h00, 1'b1);
        chk("multi_done",  32'(done), 32'h04);
        chk("multi_valid_low", 32'(out_valid), 32'd0);
        step(8'h00, 1'b0);
        chk("multi_done_clear", 32'(done), 32'd0);

        // reset while a transaction is outstanding
        step(8'h41, 1'b0);
        chk("rst_pre_requests", 32'(requests), 32'h41);
        step(8'h00, 1'b0);
        chk("rst_pre_valid", 32'(out_valid), 32'd1);
        chk("rst_pre_index", 32'(out_index), 32'd0);
        chk("rst_pre_requests2", 32'(requests), 32'h40);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_valid",    32'(out_valid), 32'd0);
        chk("rst_busy",     32'(busy), 32'd0);
        chk("rst_requests", 32'(requests), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step(8'h00, 1'b1);
            chk("post_rst_valid",    32'(out_valid), 32'd0);
            chk("post_rst_requests", 32'(requests), 32'd0);
            chk("post_rst_done",     32'(done), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/grant_dispatcher.md
Name: grant_dispatcher

Overview:
- Requester-side companion to the combinational priority arbiter: collects per-requester request pulses into sticky pending bits and drives them to the arbiter as a level request vector.
- Takes the arbiter's one-hot grant back, registers it, and issues a single valid/ready transaction (winner index plus one-hot) to the shared resource.
- Clears the winner's pending bit on handshake and pulses a per-requester completion flag.
- Sits between N client blocks and a shared resource, with the priority arbiter in the combinational loop.

Parameters:
- WORD_WIDTH, 8, number of requesters; bit 0 has highest priority via the arbiter.
- INDEX_WIDTH, 3, width of the encoded winner index; must satisfy 2**INDEX_WIDTH >= WORD_WIDTH.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_pulse  input  WORD_WIDTH  per-requester set strobe; a 1 sets that pending bit.
- requests  output  WORD_WIDTH  to arbiter; combinational, equals pending & ~inflight_mask.
- grant  input  WORD_WIDTH  from arbiter; one-hot or zero.
- out_valid  output  1  transaction valid to shared resource.
- out_ready  input  1  shared resource accepts when out_valid && out_ready.
- out_index  output  INDEX_WIDTH  binary index of the registered winner.
- out_grant  output  WORD_WIDTH  registered one-hot winner.
- done  output  WORD_WIDTH  one-cycle pulse on the bit of the requester whose transaction completed.
- busy  output  1  high in ISSUE state.

Behaviour:
- Reset (async assert, sync release): pending=0, state=IDLE, out_valid=0, out_index=0, out_grant=0, done=0, busy=0. requests is therefore 0.
- State IDLE:
  - inflight_mask=0.
  - If grant!=0 at a clock edge: out_grant<=grant, out_index<=binary index of lowest set bit of grant, out_valid<=1, state<=ISSUE.
  - If grant==0: remain in IDLE.
- State ISSUE:
  - inflight_mask=out_grant. grant is ignored.
  - out_valid, out_index and out_grant are held stable until handshake.
  - On out_valid && out_ready: pending[out_grant] clears, done<=out_grant for exactly one cycle, out_valid<=0, state<=IDLE. out_grant and out_index retain their last values.
- Pending update each edge: pending <= (pending & ~clear_vec) | req_pulse, where clear_vec is out_grant on a handshake cycle and 0 otherwise.
  - Set wins: a req_pulse on the completing bit in the handshake cycle leaves that bit pending, and it re-arbitrates.
- req_pulse on an already-pending bit has no effect; requests are not counted.
- done is 0 on every cycle other than the one following a handshake.
- Latency:
  - req_pulse at edge N sets pending at N. requests and grant are valid during cycle N. out_valid rises at edge N+1.
  - Handshake at edge M raises done during cycle M (registered, so visible after edge M), with state IDLE.
  - Next out_valid at edge M+1 at the earliest, giving one transaction per 2 cycles at best.
- Priority: new lower-index requests arriving during ISSUE do not preempt; they are served after the current handshake.
- Multi-hot grant (protocol violation): out_index encodes the lowest set bit, and out_grant registers that bit only (grant & -grant).
- out_ready while out_valid=0 is ignored.
- Reset mid-ISSUE: the transaction is dropped, out_valid falls immediately (asynchronous), and all pending bits are lost.

Test Plan:
- WORD_WIDTH=8, arbiter connected. Reset then idle -> requests=0x00, out_valid=0, done=0x00, busy=0 for 10 cycles.
- req_pulse=0x20 for one cycle, out_ready=1 -> out_valid high at next edge with out_index=5, out_grant=0x20. Handshake that cycle. Next cycle done=0x20, pending 0x00, requests=0x00.
- req_pulse=0x92 in one cycle, out_ready=1 -> serviced in order index 1, 4, 7 (out_grant 0x02, 0x10, 0x80), each out_valid pulse separated by one IDLE cycle. done pulses 0x02, 0x10, 0x80.
- out_ready=0 while serving index 4, and req_pulse=0x01 arrives -> out_valid stays high with out_index=4 stable and requests=0x01. Raise out_ready -> done=0x10, then index 0 is issued next.
- During ISSUE of index 3, req_pulse=0x08 in the handshake cycle -> done=0x08, pending bit 3 remains set, and index 3 is reissued at the next opportunity.
- reset_n asserted low mid-ISSUE with pending=0x41 -> out_valid=0, busy=0, requests=0x00 immediately. After release no transaction is issued without new req_pulse.
